sraml_axi_arbiter: RTL and testbench



---
 rtl/sraml_axi_pkg.sv | 29 ++
 rtl/sraml_arb.sv | 66 ++++++
 rtl/sraml_axi_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sraml_axi_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sraml_axi_pkg.sv
// Shared types and constants for the sram-like to AXI arbiter.
package sraml_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Byte lanes for a write; the requester has already aligned wdata.
    function automatic logic [3:0] calc_wstrb(input logic [1:0] sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_BYTE: calc_wstrb = 4'b0001 << addr_lo;
            SZ_HALF: calc_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            default: calc_wstrb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sraml_arb.sv
// Request arbiter: fixed priority (lowest index wins) by default,
// round-robin from the last-granted port when SRAML_ARB_RR_EN is defined.
module sraml_arb #(
    parameter int NPORT = 2,
    parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             take,
    output logic             grant_valid,
    output logic [NPORT-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef SRAML_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Search begins one past the last grant so every requester gets a turn.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NPORT; i++) begin
            cand = (int'(ptr_q) + i) % NPORT;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        ptr_d = (take && grant_valid) ? grant_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, rst, take};
`endif

    always_comb begin
        grant = '0;
        for (int i = 0; i < NPORT; i++) begin
            grant[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/sraml_axi_arbiter.sv
// Arbitrates NPORT sram-like masters onto one AXI master, one transaction at a time.
// Optional build macro: SRAML_ARB_RR_EN selects round-robin arbitration.
module sraml_axi_arbiter
    import sraml_axi_pkg::*;
#(
    parameter int         NPORT  = 2,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] AXI_ID = 4'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wr,
    input  logic [2*NPORT-1:0]      size,
    input  logic [ADDR_W*NPORT-1:0] addr,
    input  logic [DATA_W*NPORT-1:0] wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic [NPORT-1:0]        addr_ok,
    output logic [NPORT-1:0]        data_ok,
    output logic [3:0]              arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [DATA_W-1:0]       rdata_axi,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [DATA_W-1:0]       wdata_axi,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic              arb_valid;
    logic              arb_take;
    logic [NPORT-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;

    sraml_arb #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .take        (arb_take),
        .grant_valid (arb_valid),
        .grant       (arb_grant),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arb_take  = 1'b0;
        addr_ok   = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid && !rst) begin
                    addr_ok   = arb_grant;
                    arb_take  = 1'b1;
                    addr_d    = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    size_d    = size[2*int'(arb_idx) +: 2];
                    wdata_d   = wdata[int'(arb_idx)*DATA_W +: DATA_W];
                    idx_d     = arb_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr[arb_idx] ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: if (arready) state_d = RD_DATA;
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d = rdata_axi;
                    state_d = DONE;
                end
            end
            // Address and data channels complete independently, in either order.
            WR_REQ: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: if (bvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        data_ok = '0;
        if (state_q == DONE) data_ok[idx_q] = 1'b1;
    end

    assign rdata     = rdata_q;
    assign arvalid   = (state_q == RD_ADDR);
    assign rready    = (state_q == RD_DATA);
    assign awvalid   = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid    = (state_q == WR_REQ) && !w_done_q;
    assign bready    = (state_q == WR_RESP);

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arsize    = {1'b0, size_q};
    assign awsize    = {1'b0, size_q};
    assign wdata_axi = wdata_q;
    assign wstrb     = calc_wstrb(size_q, addr_q[1:0]);

    assign arid      = AXI_ID;
    assign awid      = AXI_ID;
    assign wid       = AXI_ID;
    assign arlen     = LEN_SINGLE;
    assign awlen     = LEN_SINGLE;
    assign arburst   = BURST_INCR;
    assign awburst   = BURST_INCR;
    assign arlock    = '0;
    assign awlock    = '0;
    assign arcache   = '0;
    assign awcache   = '0;
    assign arprot    = '0;
    assign awprot    = '0;
    assign wlast     = 1'b1;

    logic unused_axi;
    assign unused_axi = &{1'b0, rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sraml_axi_arbiter.sv
// Self-checking bench for sraml_axi_arbiter: directed scenarios plus randomized
// traffic, with the bench acting as AXI slave and predicting grants and bus fields.
`timescale 1ns/1ps
module tb_sraml_axi_arbiter;
    import sraml_axi_pkg::*;

    localparam int NPORT  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NPORT-1:0]        req;
    logic [NPORT-1:0]        wr;
    logic [2*NPORT-1:0]      size;
    logic [ADDR_W*NPORT-1:0] addr;
    logic [DATA_W*NPORT-1:0] wdata;
    logic [DATA_W-1:0]       rdata;
    logic [NPORT-1:0]        addr_ok, data_ok;
    logic [3:0]  arid, awid, wid, arcache, awcache, rid, bid;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic             p_wr    [NPORT];
    logic [1:0]       p_size  [NPORT];
    logic [31:0]      p_addr  [NPORT];
    logic [31:0]      p_wdata [NPORT];
    logic [NPORT-1:0] pending;

    int total = 0;
    int bad = 0;
    int last_grant = 0;

    always #5 clk = ~clk;

    always_comb begin
        wr = '0;
        size = '0;
        addr = '0;
        wdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            wr[i] = p_wr[i];
            size[2*i +: 2] = p_size[i];
            addr[ADDR_W*i +: ADDR_W] = p_addr[i];
            wdata[DATA_W*i +: DATA_W] = p_wdata[i];
        end
    end

    sraml_axi_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID(4'b0)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input logic w, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] d);
        p_wr[p]    = w;
        p_size[p]  = sz;
        p_addr[p]  = a;
        p_wdata[p] = d;
        pending[p] = 1'b1;
    endtask

    // Lane mask from transfer size in bytes and its naturally aligned offset.
    function automatic logic [3:0] expStrb(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        int off;
        nb  = 1 << sz;
        off = (sz == SZ_WORD) ? 0 : (int'(a[1:0]) & ~(nb - 1));
        expStrb = 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic int pickGrant(input logic [NPORT-1:0] pend, input int last);
        pickGrant = -1;
`ifdef SRAML_ARB_RR_EN
        for (int k = NPORT; k >= 1; k--) begin
            if (pend[(last + k) % NPORT]) pickGrant = (last + k) % NPORT;
        end
`else
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (pend[i]) pickGrant = i;
        end
`endif
    endfunction

    // Called at a negedge with the DUT idle; plays slave with the given ready/valid delays.
    task automatic doTxn(input int ard, input int rvd, input int awd, input int wd,
                         input int bd, input logic [31:0] rval);
        int g;
        int n;
        logic [NPORT-1:0] onehot;
        logic ew;
        logic [1:0] es;
        logic [31:0] ea, ed;
        g = pickGrant(pending, last_grant);
        if (g < 0) g = 0;
        last_grant = g;
        onehot = '0;
        onehot[g] = 1'b1;
        ew = p_wr[g];
        es = p_size[g];
        ea = p_addr[g];
        ed = p_wdata[g];
        req = pending;
        #1;
        checkOutput("addr_ok", addr_ok, onehot);
        checkOutput("data_ok_idle", data_ok, 0);
        @(negedge clk);
        pending[g] = 1'b0;
        req = pending;
        if (!ew) begin
            for (int c = 0; c <= ard; c++) begin
                arready = (c == ard);
                #1;
                checkOutput("arvalid", arvalid, 1);
                checkOutput("araddr", araddr, ea);
                checkOutput("arsize", arsize, {1'b0, es});
                checkOutput("addr_ok_busy", addr_ok, 0);
                checkOutput("rready_early", rready, 0);
                @(negedge clk);
            end
            arready = 1'b0;
            for (int c = 0; c <= rvd; c++) begin
                rvalid = (c == rvd);
                rdata_axi = (c == rvd) ? rval : $urandom;
                #1;
                checkOutput("rready", rready, 1);
                checkOutput("arvalid_late", arvalid, 0);
                checkOutput("data_ok_rd", data_ok, 0);
                @(negedge clk);
            end
            rvalid = 1'b0;
        end else begin
            n = (awd > wd) ? awd : wd;
            for (int c = 0; c <= n; c++) begin
                awready = (c == awd);
                wready  = (c == wd);
                #1;
                checkOutput("awvalid", awvalid, c <= awd);
                checkOutput("wvalid", wvalid, c <= wd);
                checkOutput("bready_early", bready, 0);
                checkOutput("addr_ok_busy", addr_ok, 0);
                if (c <= awd) begin
                    checkOutput("awaddr", awaddr, ea);
                    checkOutput("awsize", awsize, {1'b0, es});
                end
                if (c <= wd) begin
                    checkOutput("wdata", wdata_axi, ed);
                    checkOutput("wstrb", wstrb, expStrb(es, ea));
                end
                @(negedge clk);
            end
            awready = 1'b0;
            wready  = 1'b0;
            for (int c = 0; c <= bd; c++) begin
                bvalid = (c == bd);
                #1;
                checkOutput("bready", bready, 1);
                checkOutput("awvalid_late", awvalid, 0);
                checkOutput("wvalid_late", wvalid, 0);
                checkOutput("data_ok_wr", data_ok, 0);
                @(negedge clk);
            end
            bvalid = 1'b0;
        end
        #1;
        checkOutput("data_ok", data_ok, onehot);
        checkOutput("addr_ok_done", addr_ok, 0);
        checkOutput("arvalid_done", arvalid, 0);
        if (!ew) checkOutput("rdata", rdata, rval);
        @(negedge clk);
        #1;
        checkOutput("data_ok_pulse", data_ok, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        pending = '0;
        for (int i = 0; i < NPORT; i++) begin
            p_wr[i] = 1'b0;
            p_size[i] = 2'd0;
            p_addr[i] = '0;
            p_wdata[i] = '0;
        end
        arready = 0; rvalid = 0; rdata_axi = '0; rid = '0; rresp = '0; rlast = 1'b1;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_addr_ok", addr_ok, 0);
        checkOutput("rst_data_ok", data_ok, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("arlen", arlen, 0);
        checkOutput("arburst", arburst, 2'b01);
        checkOutput("awburst", awburst, 2'b01);
        checkOutput("wlast", wlast, 1);
        checkOutput("arid", arid, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] port0 word read");
        applyStimulus(0, 1'b0, SZ_WORD, 32'h1FC0_0000, 32'h0);
        doTxn(0, 0, 0, 0, 0, 32'hDEAD_BEEF);

        $display("[TB] port1 byte write");
        applyStimulus(1, 1'b1, SZ_BYTE, 32'h8000_0003, 32'hAB00_0000);
        doTxn(0, 0, 0, 0, 0, 32'h0);

        $display("[TB] contention back-to-back");
        applyStimulus(1, 1'b0, SZ_HALF, 32'h0000_2002, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (!pending[0]) applyStimulus(0, 1'(k % 2), SZ_WORD, 32'h0000_0100 + 32'(k * 4), 32'h1111_0000 + 32'(k));
            doTxn(0, 0, 0, 0, 0, 32'hC0DE_0000 + 32'(k));
        end
        for (int k = 0; k < NPORT && pending != '0; k++) doTxn(0, 0, 0, 0, 0, 32'h5A5A_0001);

        $display("[TB] write with staggered channel readies");
        applyStimulus(0, 1'b1, SZ_HALF, 32'h0000_0042, 32'h1234_0000);
        doTxn(0, 0, 0, 3, 1, 32'h0);

        $display("[TB] read with arready stalled");
        applyStimulus(1, 1'b0, SZ_WORD, 32'h0000_3000, 32'h0);
        doTxn(3, 2, 0, 0, 0, 32'h8765_4321);

        $display("[TB] reset during read data phase");
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0000_1000, 32'h0);
        req = pending;
        #1;
        checkOutput("rstseq_addr_ok", addr_ok, 2'b01);
        @(negedge clk);
        pending = '0;
        req = '0;
        arready = 1'b1;
        #1;
        checkOutput("rstseq_arvalid", arvalid, 1);
        @(negedge clk);
        arready = 1'b0;
        #1;
        checkOutput("rstseq_rready", rready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_grant = 0;
        #1;
        checkOutput("abort_rready", rready, 0);
        checkOutput("abort_arvalid", arvalid, 0);
        checkOutput("abort_awvalid", awvalid, 0);
        checkOutput("abort_wvalid", wvalid, 0);
        checkOutput("abort_bready", bready, 0);
        checkOutput("abort_data_ok", data_ok, 0);
        checkOutput("abort_rdata", rdata, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("abort_quiet", data_ok, 0);
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, SZ_WORD, 32'h1FC0_0010, 32'h0);
        doTxn(0, 0, 0, 0, 0, 32'h0BAD_F00D);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 30; t++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!pending[p] && ($urandom % 2 == 1))
                    applyStimulus(p, 1'($urandom % 2), 2'($urandom_range(0, 2)), $urandom, $urandom);
            end
            if (pending == '0)
                applyStimulus(int'($urandom % NPORT), 1'($urandom % 2), 2'($urandom_range(0, 2)), $urandom, $urandom);
            doTxn(int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                  int'($urandom % 4), int'($urandom % 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
